// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and default width for serial_subtractor
package serial_sub_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - 1-bit combinational full subtractor
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first; SERIAL_SUB_OVF_EN adds o_overflow
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    assign o_ready  = (r_state == IDLE) && !i_rst;
    assign o_valid  = (r_state == DONE);
    assign o_diff   = r_diff;
    assign o_borrow = r_borrow;
    assign w_accept = i_valid && o_ready;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    full_subtractor u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SHIFT;
            SHIFT:   if (w_last)   w_next = DONE;
            DONE:    if (i_ready)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;
    assign o_overflow = r_ovf;
`endif

    // r_borrow carries the chain between bits and ends up as the final borrow-out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_diff   <= {w_d, r_diff[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
`ifdef SERIAL_SUB_OVF_EN
            if (w_last) begin
                r_ovf <= r_borrow ^ w_bout;
            end
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_bin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         o_overflow;
`endif

    int   n_pass;
    int   n_total;
    exp_t exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_bin      (i_bin),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_diff     (o_diff),
        .o_borrow   (o_borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .o_overflow (o_overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t         e;
        logic [W:0]   full;
        int           s;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d  = full[W-1:0];
        e.b  = full[W];
        s    = $signed(a) - $signed(b) - int'(bin);
        e.o  = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return e;
    endfunction

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input int hold);
        int           guard;
        int           lat;
        exp_t         e;
        logic [W-1:0] d0;
        logic         b0;
        guard = 0;
        while (!o_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_accept", 32'(o_ready), 32'd1);
        i_a = a; i_b = b; i_bin = bin; i_valid = 1'b1;
        exp_q.push_back(model(a, b, bin));
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_a = W'($urandom); i_b = W'($urandom); i_bin = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!o_valid && lat < 3 * W);
        check("latency", 32'(lat), 32'(W));
        d0 = o_diff;
        b0 = o_borrow;
        for (int h = 0; h < hold; h++) begin
            i_ready = 1'b0;
            i_valid = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_diff", 32'({o_borrow, o_diff}), 32'({b0, d0}));
            check("hold_ready_low", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("diff", 32'(o_diff), 32'(e.d));
            check("borrow", 32'(o_borrow), 32'(e.b));
`ifdef SERIAL_SUB_OVF_EN
            check("overflow", 32'(o_overflow), 32'(e.o));
`endif
        end else begin
            check("scoreboard_empty", 32'(0), 32'(1));
        end
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("valid_drop", 32'(o_valid), 32'd0);
        check("ready_after", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int stale;
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_diff", 32'(o_diff), 32'd0);
        check("rst_borrow", 32'(o_borrow), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_first_cycle", 32'(o_ready), 32'd1);

        run_txn(4'd9, 4'd3, 1'b0, 0);
        run_txn(4'd3, 4'd9, 1'b0, 0);
        run_txn(4'd0, 4'd0, 1'b1, 0);
        run_txn(4'd15, 4'd15, 1'b1, 0);
        run_txn(4'd7, 4'd15, 1'b0, 3);
        run_txn(4'd5, 4'd2, 1'b0, 0);
        run_txn(4'd8, 4'd1, 1'b0, 1);

        i_a = 4'd5; i_b = 4'd1; i_bin = 1'b0; i_valid = 1'b1;
        exp_q.push_back(model(4'd5, 4'd1, 1'b0));
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd0);
        check("midrst_diff", 32'(o_diff), 32'd0);
        check("midrst_borrow", 32'(o_borrow), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_ready_release", 32'(o_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(posedge clk); #1;
            if (o_valid) stale++;
        end
        check("no_stale_result", 32'(stale), 32'd0);

        for (int i = 0; i < 200; i++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
